// File: rtl/ms_hold_pkg.sv
// Shared defaults and helpers for the ms_hold holding buffer family.
package ms_hold_pkg;

  localparam int MS_HOLD_DEPTH_DEF = 4;
  localparam int MS_HOLD_SIZE_DEF  = 1;

  // Pointer width for a power-of-two depth.
  function automatic int ms_hold_pw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ms_hold_ram.sv
// DEPTH x SIZE storage: one synchronous write port, one asynchronous read port, no reset.
module ms_hold_ram
  import ms_hold_pkg::*;
#(
  parameter int SIZE  = MS_HOLD_SIZE_DEF,
  parameter int DEPTH = MS_HOLD_DEPTH_DEF,
  localparam int PW   = ms_hold_pw(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [PW-1:0]   waddr,
  input  logic [SIZE-1:0] wdata,
  input  logic [PW-1:0]   raddr,
  output logic [SIZE-1:0] rdata
);

  logic [SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ms_hold_buf.sv
// Parametrised valid/ready holding buffer with flush and occupancy count.
// Optional latch-like flow-through when empty is enabled by defining MS_HOLD_BYPASS_EN.
module ms_hold_buf
  import ms_hold_pkg::*;
#(
  parameter int SIZE  = MS_HOLD_SIZE_DEF,
  parameter int DEPTH = MS_HOLD_DEPTH_DEF,
  localparam int PW   = ms_hold_pw(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk,
  input  logic            reset_l,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] q,
  output logic [CW-1:0]   count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic [SIZE-1:0] rdata;
  logic            empty;
  logic            full;
  logic            byp;
  logic            push;
  logic            pop_mem;
  logic            we;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

`ifdef MS_HOLD_BYPASS_EN
  assign byp = empty && in_valid;
`else
  assign byp = 1'b0;
`endif

  assign in_ready  = !full;
  assign out_valid = !empty || byp;
  assign count     = cnt;

  always_comb begin
    q = '0;
    if (!empty)   q = rdata;
    else if (byp) q = d;
  end

  // A word that flows straight through an empty buffer never touches storage.
  assign push    = in_valid && in_ready && !(byp && out_ready);
  assign pop_mem = out_ready && !empty;
  assign we      = push && !flush;

  ms_hold_ram #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (d),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_l || flush) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + PW'(1);
      if (pop_mem) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop_mem)      cnt <= cnt + CW'(1);
      else if (pop_mem && !push) cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_ms_hold_buf.sv
// Scoreboard bench for ms_hold_buf (SIZE=8, DEPTH=4); bypass expectations follow MS_HOLD_BYPASS_EN.
module tb_ms_hold_buf;

`ifdef MS_HOLD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_l;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;
  logic [2:0] count;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  ms_hold_buf #(
    .SIZE  (8),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset_l   (reset_l),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .count     (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called just after a rising edge: drive, sample at the falling edge, update model, advance.
  task automatic cycle(input logic iv, input logic [7:0] dd, input logic ordy, input logic fl);
    bit exp_byp;
    bit do_pop;
    bit do_push;
    in_valid  = iv;
    d         = dd;
    out_ready = ordy;
    flush     = fl;
    #4;
    exp_byp = BYP && (sb.size() == 0) && iv;
    check("count", count, sb.size());
    check("in_ready", in_ready, sb.size() != 4);
    check("out_valid", out_valid, (sb.size() != 0) || exp_byp);
    if (sb.size() != 0)  check("q_head", q, sb[0]);
    else if (exp_byp)    check("q_bypass", q, dd);
    else                 check("q_idle", q, 0);
    do_pop  = ordy && (sb.size() != 0);
    do_push = iv && (sb.size() != 4) && !(exp_byp && ordy);
    if (fl) sb.delete();
    else begin
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(dd);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_l   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    d         = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_l = 1'b1;

    // Reset then idle.
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // reset_l pulse with no clock edge must change nothing.
    cycle(1'b1, 8'hC1, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0, 1'b0);
    reset_l = 1'b0;
    #2;
    reset_l = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset at an edge mid-transfer discards everything.
    in_valid = 1'b1;
    d        = 8'hC3;
    reset_l  = 1'b0;
    @(posedge clk);
    #1;
    reset_l = 1'b1;
    sb.delete();
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill, overflow attempt, drain.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Continuous streaming at count=2, pointers wrap repeatedly.
    cycle(1'b1, 8'd0, 1'b0, 1'b0);
    cycle(1'b1, 8'd1, 1'b0, 1'b0);
    for (int i = 2; i < 22; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Full with push and pop together: pop only, then push accepted.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hB0, 1'b1, 1'b0);
    cycle(1'b1, 8'hB1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush at count=3 with a simultaneous push of 0xAA.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Empty buffer offered a word with the consumer ready.
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Empty buffer offered a word with the consumer stalled: always a real push.
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ms_hold_buf.md
# ms_hold_buf

Parametrised holding buffer, successor to the single-entry level latch. It stores up to DEPTH words of SIZE bits behind a valid/ready handshake on both sides, and adds flush, occupancy reporting and an optional latch-like flow-through path. It sits between RCP producer/consumer stages that need decoupling deeper than one register.

## Interface
- SIZE, 1: data width in bits
- DEPTH, 4: number of entries; power of two, ≥ 2
- CW, log2(DEPTH)+1: width of count (derived, not overridden)

- clk  input  1  clock; all state changes on rising edge
- reset_l  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- flush  input  1  synchronous clear of all entries
- in_valid  input  1  producer has a word on d
- in_ready  output  1  buffer accepts a word this cycle
- d  input  SIZE  write data
- out_valid  output  1  q holds a valid word
- out_ready  input  1  consumer takes q this cycle
- q  output  SIZE  read data
- count  output  CW  current number of stored entries, 0..DEPTH

## Operation
- Push: in_valid && in_ready. Writes d at wr_ptr; wr_ptr advances modulo DEPTH.
- Pop: out_valid && out_ready. rd_ptr advances modulo DEPTH.
- in_ready = (count != DEPTH). It does not depend on out_ready. When full, a pop that cycle does not enable a push in the same cycle.
- out_valid = (count != 0), except for the bypass case (see Configuration).
- q = mem[rd_ptr] when count != 0. Otherwise q = 0, or d in the bypass case.
- count next value:
  - push and no pop: count+1
  - pop and no push: count−1
  - both, or neither: unchanged
- Simultaneous push and pop at 0 < count < DEPTH: both pointers advance and count is unchanged.
- Pointer wrap: the pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished only by count.
- Flush has precedence over push and pop in the same cycle:
  - next count = 0, wr_ptr = rd_ptr = 0
  - the data written that cycle is discarded
  - in_ready remains as computed from the current count
- Reset (reset_l low at an edge) forces count = 0 and both pointers = 0. The storage array is not reset.
- Reset applied mid-transfer discards all contents. No partial state survives.
- Output values after reset: in_ready = 1, out_valid = 0, q = 0 (no bypass), count = 0.

## Timing
- Write-to-read latency without bypass: a word pushed at edge N is visible on q with out_valid = 1 after edge N.
- Write-to-read latency with bypass, when empty: 0 cycles.
- Sustained throughput: 1 word per cycle whenever 0 < count < DEPTH.
- All outputs are combinational decodes of registered state. The only combinational input-to-output paths are:
  - d to q, and in_valid to out_valid, in bypass mode only.
- No combinational path from out_ready to in_ready in any mode.

## Configuration
- MS_HOLD_BYPASS_EN defined:
  - When count == 0 and in_valid = 1: out_valid = 1 and q = d, i.e. transparent like the latch.
  - If out_ready is also 1, the word passes straight through. No write occurs and count stays 0.
  - If out_ready = 0, a normal push occurs.
- MS_HOLD_BYPASS_EN undefined:
  - No d→q path; the word always lands in storage first.
  - An empty buffer always shows out_valid = 0.
- Flush in bypass mode does not suppress the combinational out_valid for that cycle. The producer must not assert flush together with an expected bypass transfer.

## Structure
- Shared package ms_hold_pkg:
  - MS_HOLD_DEPTH_DEF (4) and MS_HOLD_SIZE_DEF (1)
  - pointer-width function ms_hold_pw(depth) = log2(depth)
- Sub-module ms_hold_ram: DEPTH×SIZE array, one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr → rdata). No reset.
- ms_hold_buf contains the pointers, count, handshake decode, flush and bypass mux.

## Test plan
- Reset then idle, SIZE=8, DEPTH=4: in_ready=1, out_valid=0, count=0, q=0 held for 10 cycles. This holds only with reset_l low at an edge; reset_l low with no clock edge must change nothing.
- Push 0x11, 0x22, 0x33, 0x44 with out_ready=0 → count=4 and in_ready=0. A fifth push of 0x55 is ignored. Then drain with out_ready=1 → q = 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then out_valid=0.
- Continuous push and pop for 20 cycles with data 0..19 at count=2 → count stays 2, output order is 0..19 delayed by 2 cycles, and the pointers wrap 5 times without error.
- Full buffer with in_valid=1 and out_ready=1 in the same cycle → pop occurs, no push, count=3. A push is accepted on the next cycle.
- Flush asserted with count=3 together with a push of 0xAA → next cycle count=0 and out_valid=0. 0xAA never appears on q.
- With MS_HOLD_BYPASS_EN: empty buffer, in_valid=1, d=0x5A, out_ready=1 → same-cycle out_valid=1, q=0x5A, and count stays 0. Without the macro, the same stimulus gives out_valid=0 in that cycle, then q=0x5A with count=1 after the edge.
